// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with one-entry skid buffer; ex_ready is registered to cut the ready path.
// Latency: 1 cycle from accept to mem_valid; sustains 1 instr/cycle while mem_ready stays high.
// Backpressure: the skid entry absorbs the instruction already accepted under a registered ex_ready; ex_ready drops while both entries are held.
module ex_mem_skid_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [XLEN-1:0]   ex_pc,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_RegWrite,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [REG_AW-1:0] mem_rd_addr,
    output logic [2:0]        mem_funct3,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic [XLEN-1:0]   mem_store_data,
    output logic [XLEN-1:0]   mem_pc,
    output logic              fwd_RegWrite
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [REG_AW-1:0] rd_addr;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   pc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, ex_entry;
    logic   ex_ready_q;
    logic   accept, consume;
    logic   ld_main_ex, ld_main_skid, ld_skid;

    assign ex_entry = '{reg_write:  ex_RegWrite,
                        mem_read:   ex_MemRead,
                        mem_write:  ex_MemWrite,
                        rd_addr:    ex_rd_addr,
                        funct3:     ex_funct3,
                        alu_result: ex_alu_result,
                        store_data: ex_store_data,
                        pc:         ex_pc};

    assign mem_valid = (state_q != EMPTY);
    assign ex_ready  = ex_ready_q;
    assign accept    = ex_valid & ex_ready_q;
    assign consume   = mem_valid & mem_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_ex   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = FULL;
                        ld_main_ex = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        ld_main_ex = 1'b1;
                    end else if (accept) begin
                        state_d = SKID;
                        ld_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (consume) begin
                        state_d      = FULL;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ex_ready is registered from the next state so it never sees mem_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ex_ready_q <= (state_d != SKID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_ex) begin
                main_q <= ex_entry;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= ex_entry;
            end
        end
    end

    // Control bits are qualified by mem_valid so a stale main entry never looks live.
    assign mem_RegWrite   = mem_valid & main_q.reg_write;
    assign mem_MemRead    = mem_valid & main_q.mem_read;
    assign mem_MemWrite   = mem_valid & main_q.mem_write;
    assign mem_rd_addr    = main_q.rd_addr;
    assign mem_funct3     = main_q.funct3;
    assign mem_alu_result = main_q.alu_result;
    assign mem_store_data = main_q.store_data;
    assign mem_pc         = main_q.pc;

    assign fwd_RegWrite = mem_valid & main_q.reg_write & ~main_q.mem_read;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios plus randomized traffic against a 2-deep queue model.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
    } item_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    logic   ex_valid = 1'b0;
    logic   mem_ready = 1'b0;
    item_t  ex_in = '0;
    item_t  obs;
    logic   ex_ready, mem_valid, fwd_RegWrite;
    logic   mem_RegWrite, mem_MemRead, mem_MemWrite;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_store_data, mem_pc;

    int errors = 0;
    int checks = 0;
    item_t mq[$];

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_RegWrite    (ex_in.rw),
        .ex_MemRead     (ex_in.mr),
        .ex_MemWrite    (ex_in.mw),
        .ex_rd_addr     (ex_in.rd),
        .ex_funct3      (ex_in.f3),
        .ex_alu_result  (ex_in.alu),
        .ex_store_data  (ex_in.sd),
        .ex_pc          (ex_in.pc),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_RegWrite   (mem_RegWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_rd_addr    (mem_rd_addr),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_pc         (mem_pc),
        .fwd_RegWrite   (fwd_RegWrite)
    );

    assign obs = '{rw: mem_RegWrite, mr: mem_MemRead, mw: mem_MemWrite, rd: mem_rd_addr,
                   f3: mem_funct3, alu: mem_alu_result, sd: mem_store_data, pc: mem_pc};

    // Reference: an in-order buffer of at most two instructions; ready whenever it has room.
    task automatic step();
        bit do_pop, do_push;
        @(posedge clk);
        do_pop  = (mq.size() > 0) && mem_ready;
        do_push = ex_valid && (mq.size() < 2);
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ex_in);
        end
        #1;
    endtask

    task automatic alu_op(input logic [31:0] v);
        ex_in     = '0;
        ex_in.rw  = 1'b1;
        ex_in.rd  = 5'd3;
        ex_in.alu = v;
        ex_in.pc  = 32'h1000 + v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        checks++; if (fwd_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_fwd got=%b exp=0", fwd_RegWrite); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        step();
    endtask

    task automatic test_stream();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1;
            alu_op(32'h10 + i);
            step();
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, mem_valid); end
            checks++; if (mem_alu_result !== 32'h10 + i) begin errors++; $display("FAIL stream_result[%0d] got=%h exp=%h", i, mem_alu_result, 32'h10 + i); end
            checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ex_ready); end
        end
        ex_valid = 1'b0;
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", mem_valid); end
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        alu_op(32'hA);
        step();
        alu_op(32'hB);
        step();
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got=%b exp=0", ex_ready); end
        checks++; if (mem_alu_result !== 32'hA) begin errors++; $display("FAIL bp_head got=%h exp=a", mem_alu_result); end
        alu_op(32'hC);
        step();
        checks++; if (mem_alu_result !== 32'hA || ex_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got=%h/%b exp=a/0", mem_alu_result, ex_ready); end
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        step();
        checks++; if (mem_alu_result !== 32'hB || mem_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%b exp=b/1", mem_alu_result, mem_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", ex_ready); end
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", mem_valid); end
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        alu_op(32'h21); step();
        alu_op(32'h22); step();
        alu_op(32'hEE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL flush_skid got=%b/%b exp=0/1", mem_valid, ex_ready); end
        ex_valid = 1'b0;
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_captured got=%b exp=0", mem_valid); end
        ex_valid = 1'b1;
        alu_op(32'h31); step();
        alu_op(32'h32);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        step();
        checks++; if (mem_valid !== 1'b0 || mem_RegWrite !== 1'b0) begin errors++; $display("FAIL flush_full got=%b/%b exp=0/0", mem_valid, mem_RegWrite); end
    endtask

    task automatic test_fwd();
        mem_ready = 1'b1;
        ex_valid  = 1'b1;
        ex_in = '0; ex_in.rw = 1'b1; ex_in.mr = 1'b1; ex_in.rd = 5'd5; ex_in.alu = 32'h400;
        step();
        checks++; if (fwd_RegWrite !== 1'b0 || mem_MemRead !== 1'b1) begin errors++; $display("FAIL fwd_load got=%b/%b exp=0/1", fwd_RegWrite, mem_MemRead); end
        ex_in.mr = 1'b0;
        step();
        checks++; if (fwd_RegWrite !== 1'b1 || mem_rd_addr !== 5'd5) begin errors++; $display("FAIL fwd_alu got=%b/%0d exp=1/5", fwd_RegWrite, mem_rd_addr); end
        ex_in.rd = 5'd0;
        ex_in.mw = 1'b1;
        step();
        checks++; if (fwd_RegWrite !== 1'b1 || mem_rd_addr !== 5'd0 || mem_MemWrite !== 1'b1) begin errors++; $display("FAIL fwd_x0 got=%b/%0d/%b exp=1/0/1", fwd_RegWrite, mem_rd_addr, mem_MemWrite); end
        ex_valid = 1'b0;
        step();
        checks++; if (fwd_RegWrite !== 1'b0 || mem_RegWrite !== 1'b0) begin errors++; $display("FAIL fwd_bubble got=%b/%b exp=0/0", fwd_RegWrite, mem_RegWrite); end
    endtask

    task automatic test_async_reset();
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        alu_op(32'h41); step();
        alu_op(32'h42); step();
        ex_valid = 1'b0;
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL arst_pre got=%b exp=0", ex_ready); end
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL arst_immediate got=%b/%b exp=0/1", mem_valid, ex_ready); end
        checks++; if (mem_alu_result !== 32'h0 || mem_RegWrite !== 1'b0) begin errors++; $display("FAIL arst_clear got=%h/%b exp=0/0", mem_alu_result, mem_RegWrite); end
        #1;
        rst_n = 1'b1;
        ex_valid = 1'b1;
        alu_op(32'h55);
        step();
        ex_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h55 || ex_ready !== 1'b1) begin errors++; $display("FAIL arst_first got=%b/%h/%b exp=1/55/1", mem_valid, mem_alu_result, ex_ready); end
        step();
    endtask

    task automatic test_random();
        int bad = 0;
        int popped = 0;
        for (int c = 0; c < 10000; c++) begin
            ex_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            ex_in.rw  = $urandom_range(0, 1);
            ex_in.mr  = $urandom_range(0, 1);
            ex_in.mw  = $urandom_range(0, 1);
            ex_in.rd  = 5'($urandom);
            ex_in.f3  = 3'($urandom);
            ex_in.alu = $urandom;
            ex_in.sd  = $urandom;
            ex_in.pc  = $urandom;
            checks++;
            if (mem_valid !== (mq.size() > 0) || ex_ready !== (mq.size() < 2)) begin
                errors++;
                if (bad++ < 10) $display("FAIL rand_state cyc=%0d valid/ready got=%b/%b exp=%b/%b", c, mem_valid, ex_ready, mq.size() > 0, mq.size() < 2);
            end else if (mq.size() > 0) begin
                checks++;
                if (obs !== mq[0] || fwd_RegWrite !== (mq[0].rw & ~mq[0].mr)) begin
                    errors++;
                    if (bad++ < 10) $display("FAIL rand_head cyc=%0d got=%h fwd=%b exp=%h", c, obs, fwd_RegWrite, mq[0]);
                end
                if (mem_ready && !flush) popped++;
            end else begin
                checks++;
                if ({mem_RegWrite, mem_MemRead, mem_MemWrite, fwd_RegWrite} !== 4'b0) begin
                    errors++;
                    if (bad++ < 10) $display("FAIL rand_idle_ctl cyc=%0d got=%b exp=0000", c, {mem_RegWrite, mem_MemRead, mem_MemWrite, fwd_RegWrite});
                end
            end
            step();
        end
        flush = 1'b0;
        ex_valid = 1'b0;
        checks++; if (popped < 1000) begin errors++; $display("FAIL rand_traffic consumed=%0d exp>=1000", popped); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_fwd();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width.
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-003 The block SHALL have these ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have these ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have these ports: flush  input  1  squash all held entries (branch/trap redirect).
REQ-006 The block SHALL have these ports: ex_valid  input  1  EX presents an instruction.
REQ-007 The block SHALL have these ports: ex_ready  output  1  block accepts this cycle.
REQ-008 The block SHALL have these ports: ex_RegWrite, ex_MemRead, ex_MemWrite  input  1 each  EX control bits.
REQ-009 The block SHALL have these ports: ex_rd_addr  input  REG_AW  destination register.
REQ-010 The block SHALL have these ports: ex_funct3  input  3  memory access size/sign.
REQ-011 The block SHALL have these ports: ex_alu_result, ex_store_data, ex_pc  input  XLEN each  EX results.
REQ-012 The block SHALL have these ports: mem_valid  output  1  MEM-side entry valid.
REQ-013 The block SHALL have these ports: mem_ready  input  1  MEM stage consumes this cycle.
REQ-014 The block SHALL have these ports: mem_RegWrite, mem_MemRead, mem_MemWrite, mem_rd_addr, mem_funct3, mem_alu_result, mem_store_data, mem_pc  output  widths as EX  held entry fields.
REQ-015 The block SHALL have these ports: fwd_RegWrite  output  1  forwarding-qualified write enable for the MEM-stage forward source.

Function
REQ-016 Storage SHALL be a main entry (drives mem_* outputs) plus one skid entry; state encoded as EMPTY, FULL (main only), SKID (main+skid).
REQ-017 ex_ready SHALL be a registered signal equal to 1 in EMPTY and FULL, 0 in SKID; it SHALL NOT depend combinationally on mem_ready.
REQ-018 Accept SHALL occur when ex_valid & ex_ready; consume when mem_valid & mem_ready; mem_valid SHALL equal 1 in FULL and SKID.
REQ-019 EMPTY: accept -> FULL, main loaded; no accept -> stay.
REQ-020 FULL: accept & consume -> FULL, main reloaded from EX; accept & !consume -> SKID, skid loaded from EX, main unchanged; !accept & consume -> EMPTY; neither -> stay.
REQ-021 SKID: consume -> FULL, main loaded from skid; !consume -> stay, both entries unchanged; no accept possible.
REQ-022 Order SHALL be preserved: the skid entry always issues after the main entry; zero instructions dropped or duplicated.
REQ-023 Latency SHALL be exactly 1 cycle from accept to mem_valid in EMPTY; throughput 1/cycle while mem_ready held high.
REQ-024 flush SHALL take priority over accept and consume: next state EMPTY, ex_ready=1 next cycle, in-flight accept discarded.
REQ-025 fwd_RegWrite SHALL equal mem_valid & mem_RegWrite & !mem_MemRead (combinational), so loads and bubbles never forward ALU data; mem_rd_addr=0 SHALL be passed unchanged (zero-register filtering belongs downstream).
REQ-026 Payload registers SHALL only load on their enable; when mem_valid=0 mem_RegWrite, mem_MemRead, mem_MemWrite SHALL read 0.
REQ-027 Payload widths SHALL be passed through unmodified; no arithmetic performed.

Reset
REQ-028 On rst_n low, asynchronously: state EMPTY, mem_valid=0, ex_ready=1, all control outputs 0, all data outputs 0.
REQ-029 Reset asserted mid-SKID SHALL discard both entries; first accept after release behaves as from EMPTY.

Verification
REQ-030 Stream: mem_ready=1, 4 back-to-back ex_valid with alu_result 0x10..0x13 -> mem_valid from cycle 1, results 0x10..0x13 in order, ex_ready stays 1.
REQ-031 Backpressure: accept A(0xA), B(0xB) while mem_ready=0 -> state SKID, ex_ready=0, mem_alu_result=0xA; raise mem_ready -> 0xA then 0xB consumed, ex_ready=1 after first consume.
REQ-032 Flush in SKID with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, EX instruction not captured.
REQ-033 Load forward gating: accept RegWrite=1, MemRead=1, rd=5 -> fwd_RegWrite=0; ALU op RegWrite=1, rd=5 -> fwd_RegWrite=1; bubble -> 0.
REQ-034 Async reset: drop rst_n between clock edges while SKID -> mem_valid=0, ex_ready=1 immediately, no clock required.
REQ-035 Random valid/ready/flush, 10k cycles, scoreboard -> no loss, duplication or reorder outside flush windows.
